// File: rtl/lsu_wb_bridge_pkg.sv
// ============================================================================
// lsu_wb_bridge_pkg : shared size codes, FSM states and lane-mask helper
// Revision 1.0
// ============================================================================
`default_nettype none

package lsu_wb_bridge_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BEAT0 = 3'd1,
    ST_GAP   = 3'd2,
    ST_BEAT1 = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Right-justified byte-enable mask for an access size (up to 8 lanes).
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  size_mask = 8'h01;
      SIZE_H:  size_mask = 8'h03;
      SIZE_W:  size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_wb_bridge_lane_align.sv
// ============================================================================
// lsu_wb_bridge_lane_align : byte-lane selects, store shift, load merge/extend
// Revision 1.0
// ============================================================================
`default_nettype none

module lsu_wb_bridge_lane_align
  import lsu_wb_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [$clog2(DATA_WIDTH/8)-1:0] offset,
  input  logic [1:0]                      size,
  input  logic                            is_unsigned,
  input  logic [DATA_WIDTH-1:0]           store_data,
  input  logic [DATA_WIDTH-1:0]           rd_lo,
  input  logic [DATA_WIDTH-1:0]           rd_hi,
  output logic [DATA_WIDTH/8-1:0]         sel_lo,
  output logic [DATA_WIDTH/8-1:0]         sel_hi,
  output logic [DATA_WIDTH-1:0]           wdata_lo,
  output logic [DATA_WIDTH-1:0]           wdata_hi,
  output logic [DATA_WIDTH-1:0]           load_data,
  output logic                            spill
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);

  logic [NB-1:0]           bmask;
  logic [2*NB-1:0]         sel_wide;
  logic [OFFW+2:0]         bshift;
  logic [DATA_WIDTH-1:0]   sdata_m;
  logic [DATA_WIDTH-1:0]   raw;
  logic [2*DATA_WIDTH-1:0] wdata_wide;
  logic [2*DATA_WIDTH-1:0] rdata_wide;
  logic                    msb;

  assign bmask      = NB'(size_mask(size));
  assign bshift     = {offset, 3'b000};
  assign sel_wide   = {{NB{1'b0}}, bmask} << offset;
  assign sel_lo     = sel_wide[NB-1:0];
  assign sel_hi     = sel_wide[2*NB-1:NB];
  assign spill      = |sel_hi;

  assign wdata_wide = {{DATA_WIDTH{1'b0}}, sdata_m} << bshift;
  assign wdata_lo   = wdata_wide[DATA_WIDTH-1:0];
  assign wdata_hi   = wdata_wide[2*DATA_WIDTH-1:DATA_WIDTH];

  // Beat-1 lanes sit above beat-0 lanes, so one right shift merges both.
  assign rdata_wide = {rd_hi, rd_lo} >> bshift;
  assign raw        = rdata_wide[DATA_WIDTH-1:0];

  always_comb begin
    msb = raw[DATA_WIDTH-1];
    case (size)
      SIZE_B:  msb = raw[7];
      SIZE_H:  msb = raw[15];
      SIZE_W:  msb = raw[31];
      default: msb = raw[DATA_WIDTH-1];
    endcase
  end

  for (genvar b = 0; b < NB; b++) begin : g_lane
    assign sdata_m[8*b +: 8]   = store_data[8*b +: 8] & {8{bmask[b]}};
    assign load_data[8*b +: 8] = bmask[b] ? raw[8*b +: 8] : {8{msb & ~is_unsigned}};
  end

endmodule

`default_nettype wire

// File: rtl/lsu_wb_bridge.sv
// ============================================================================
// lsu_wb_bridge : LSU to Wishbone master with sizing, misalign split, timeout
// Revision 1.0
// ============================================================================
`default_nettype none

module lsu_wb_bridge
  import lsu_wb_bridge_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int SPLIT_MISALIGN = 1
) (
  input  logic                    i_CLK,
  input  logic                    i_RSTn,
  input  logic                    i_LSU_REQ,
  input  logic [ADDR_WIDTH-1:0]   i_LSU_ADDR,
  input  logic [DATA_WIDTH-1:0]   i_LSU_DATA,
  input  logic                    i_LSU_WE,
  input  logic [1:0]              i_LSU_SIZE,
  input  logic                    i_LSU_UNSIGNED,
  output logic [DATA_WIDTH-1:0]   o_LSU_DATA,
  output logic                    o_LSU_GNT,
  output logic                    o_LSU_ERR,
  output logic [ADDR_WIDTH-1:0]   o_WB_ADDR,
  output logic [DATA_WIDTH-1:0]   o_WB_DATA,
  input  logic [DATA_WIDTH-1:0]   i_WB_DATA,
  output logic                    o_WB_WE,
  output logic [DATA_WIDTH/8-1:0] o_WB_SEL,
  output logic                    o_WB_STB,
  output logic                    o_WB_CYC,
  input  logic                    i_WB_ACK,
  input  logic                    i_WB_ERR,
  output logic                    o_WB_TAGN,
  input  logic                    i_WB_TAGN
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t                state, state_nxt;
  logic [OFFW-1:0]       off_q, off_nxt;
  logic [1:0]            size_q, size_nxt;
  logic [DATA_WIDTH-1:0] sdata_q, sdata_nxt;
  logic                  we_q, we_nxt, uns_q, uns_nxt, split_q, split_nxt;
  logic [DATA_WIDTH-1:0] rd0_q, rd0_nxt;
  logic [TW-1:0]         tmo_cnt, tmo_nxt;

  logic [ADDR_WIDTH-1:0] wb_addr, wb_addr_nxt;
  logic [DATA_WIDTH-1:0] wb_data, wb_data_nxt;
  logic [NB-1:0]         wb_sel, wb_sel_nxt;
  logic                  wb_we, wb_we_nxt, wb_stb, wb_stb_nxt, wb_cyc, wb_cyc_nxt;
  logic                  wb_tagn, wb_tagn_nxt;
  logic                  gnt, gnt_nxt, err, err_nxt;
  logic [DATA_WIDTH-1:0] ldata, ldata_nxt;

  logic                  idle, illegal, bus_err, tmo_hit, close_bus;
  logic [OFFW-1:0]       cur_off;
  logic [1:0]            cur_size;
  logic [DATA_WIDTH-1:0] cur_data, rd_lo;
  logic                  cur_uns;
  logic [NB-1:0]         sel_lo, sel_hi;
  logic [DATA_WIDTH-1:0] wdata_lo, wdata_hi, load_data;
  logic                  spill;

  // In IDLE the first beat is launched from the live request, later from captures.
  assign idle     = (state == ST_IDLE);
  assign cur_off  = idle ? i_LSU_ADDR[OFFW-1:0] : off_q;
  assign cur_size = idle ? i_LSU_SIZE : size_q;
  assign cur_data = idle ? i_LSU_DATA : sdata_q;
  assign cur_uns  = idle ? i_LSU_UNSIGNED : uns_q;
  assign rd_lo    = split_q ? rd0_q : i_WB_DATA;
  assign illegal  = (NB < 8) && (cur_size == SIZE_D);
  assign bus_err  = i_WB_ERR | (i_WB_ACK & ~i_WB_TAGN);
  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

  lsu_wb_bridge_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .offset      (cur_off),
    .size        (cur_size),
    .is_unsigned (cur_uns),
    .store_data  (cur_data),
    .rd_lo       (rd_lo),
    .rd_hi       (i_WB_DATA),
    .sel_lo      (sel_lo),
    .sel_hi      (sel_hi),
    .wdata_lo    (wdata_lo),
    .wdata_hi    (wdata_hi),
    .load_data   (load_data),
    .spill       (spill)
  );

  always_comb begin
    state_nxt = state;     off_nxt = off_q;     size_nxt = size_q;
    sdata_nxt = sdata_q;   we_nxt = we_q;       uns_nxt = uns_q;
    split_nxt = split_q;   rd0_nxt = rd0_q;     tmo_nxt = tmo_cnt;
    wb_addr_nxt = wb_addr; wb_data_nxt = wb_data; wb_sel_nxt = wb_sel;
    wb_we_nxt = wb_we;     wb_stb_nxt = wb_stb; wb_cyc_nxt = wb_cyc;
    wb_tagn_nxt = wb_tagn;
    gnt_nxt = 1'b0;        err_nxt = 1'b0;      ldata_nxt = '0;
    close_bus = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_LSU_REQ) begin
          off_nxt   = i_LSU_ADDR[OFFW-1:0];
          size_nxt  = i_LSU_SIZE;
          sdata_nxt = i_LSU_DATA;
          we_nxt    = i_LSU_WE;
          uns_nxt   = i_LSU_UNSIGNED;
          split_nxt = spill;
          if (illegal || (spill && SPLIT_MISALIGN == 0)) begin
            state_nxt = ST_DONE;
            gnt_nxt   = 1'b1;
            err_nxt   = 1'b1;
          end else begin
            state_nxt   = ST_BEAT0;
            wb_cyc_nxt  = 1'b1;
            wb_stb_nxt  = 1'b1;
            wb_we_nxt   = i_LSU_WE;
            wb_addr_nxt = {i_LSU_ADDR[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
            wb_sel_nxt  = sel_lo;
            wb_data_nxt = i_LSU_WE ? wdata_lo : '0;
            wb_tagn_nxt = ~spill;
            tmo_nxt     = '0;
          end
        end
      end
      ST_BEAT0, ST_BEAT1: begin
        if (bus_err || (!i_WB_ACK && tmo_hit)) begin
          close_bus = 1'b1;
          state_nxt = ST_DONE;
          gnt_nxt   = 1'b1;
          err_nxt   = 1'b1;
        end else if (i_WB_ACK) begin
          if (state == ST_BEAT0 && split_q) begin
            state_nxt   = ST_GAP;
            wb_stb_nxt  = 1'b0;
            wb_tagn_nxt = 1'b1;
            rd0_nxt     = i_WB_DATA;
          end else begin
            close_bus = 1'b1;
            state_nxt = ST_DONE;
            gnt_nxt   = 1'b1;
            ldata_nxt = we_q ? '0 : load_data;
          end
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end
      ST_GAP: begin
        state_nxt   = ST_BEAT1;
        wb_stb_nxt  = 1'b1;
        wb_addr_nxt = wb_addr + ADDR_WIDTH'(NB);
        wb_sel_nxt  = sel_hi;
        wb_data_nxt = we_q ? wdata_hi : '0;
        tmo_nxt     = '0;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (close_bus) begin
      wb_cyc_nxt  = 1'b0;
      wb_stb_nxt  = 1'b0;
      wb_we_nxt   = 1'b0;
      wb_sel_nxt  = '0;
      wb_data_nxt = '0;
      wb_tagn_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      state <= ST_IDLE;  off_q <= '0;   size_q <= '0;  sdata_q <= '0;
      we_q <= 1'b0;      uns_q <= 1'b0; split_q <= 1'b0; rd0_q <= '0;
      tmo_cnt <= '0;     wb_addr <= '0; wb_data <= '0; wb_sel <= '0;
      wb_we <= 1'b0;     wb_stb <= 1'b0; wb_cyc <= 1'b0; wb_tagn <= 1'b1;
      gnt <= 1'b0;       err <= 1'b0;   ldata <= '0;
    end else begin
      state <= state_nxt;  off_q <= off_nxt;   size_q <= size_nxt; sdata_q <= sdata_nxt;
      we_q <= we_nxt;      uns_q <= uns_nxt;   split_q <= split_nxt; rd0_q <= rd0_nxt;
      tmo_cnt <= tmo_nxt;  wb_addr <= wb_addr_nxt; wb_data <= wb_data_nxt; wb_sel <= wb_sel_nxt;
      wb_we <= wb_we_nxt;  wb_stb <= wb_stb_nxt; wb_cyc <= wb_cyc_nxt; wb_tagn <= wb_tagn_nxt;
      gnt <= gnt_nxt;      err <= err_nxt;     ldata <= ldata_nxt;
    end
  end

  assign o_LSU_DATA = ldata;
  assign o_LSU_GNT  = gnt;
  assign o_LSU_ERR  = err;
  assign o_WB_ADDR  = wb_addr;
  assign o_WB_DATA  = wb_data;
  assign o_WB_WE    = wb_we;
  assign o_WB_SEL   = wb_sel;
  assign o_WB_STB   = wb_stb;
  assign o_WB_CYC   = wb_cyc;
  assign o_WB_TAGN  = wb_tagn;

endmodule

`default_nettype wire

// File: tb/tb_lsu_wb_bridge.sv
// ============================================================================
// tb_lsu_wb_bridge : directed scoreboard bench with a scripted Wishbone slave
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_lsu_wb_bridge;

  localparam int K_ACK = 0, K_ERR = 1, K_NONE = 2, K_BOTH = 3, K_TAG = 4;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wdata;
    logic        tagn;
    logic [31:0] rdata;
    int          wcyc;
    int          kind;
    int          exp_len;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } resp_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req = 1'b0, lsu_we = 1'b0, lsu_uns = 1'b0;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0;
  logic [1:0]  lsu_size = '0;
  logic [31:0] lsu_rdata, wb_addr, wb_wdata;
  logic        gnt, lerr, wb_we, wb_stb, wb_cyc, wb_tagn_o;
  logic [3:0]  wb_sel;
  logic [31:0] wb_rdata = '0;
  logic        wb_ack = 1'b0, wb_err = 1'b0, wb_tagn_i = 1'b1;

  int checks = 0, failures = 0;
  int cyc_cnt = 0, req_cyc = 0;
  beat_t beat_q[$];
  resp_t exp_q[$];
  beat_t cur;
  logic  active = 1'b0;
  int    hi_cnt = 0, waitc = 0;

  lsu_wb_bridge #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4), .SPLIT_MISALIGN(1)
  ) dut (
    .i_CLK(clk), .i_RSTn(rst_n),
    .i_LSU_REQ(req), .i_LSU_ADDR(lsu_addr), .i_LSU_DATA(lsu_wdata),
    .i_LSU_WE(lsu_we), .i_LSU_SIZE(lsu_size), .i_LSU_UNSIGNED(lsu_uns),
    .o_LSU_DATA(lsu_rdata), .o_LSU_GNT(gnt), .o_LSU_ERR(lerr),
    .o_WB_ADDR(wb_addr), .o_WB_DATA(wb_wdata), .i_WB_DATA(wb_rdata),
    .o_WB_WE(wb_we), .o_WB_SEL(wb_sel), .o_WB_STB(wb_stb), .o_WB_CYC(wb_cyc),
    .i_WB_ACK(wb_ack), .i_WB_ERR(wb_err), .o_WB_TAGN(wb_tagn_o), .i_WB_TAGN(wb_tagn_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic [31:0] a, input logic [3:0] s, input logic we,
                           input logic [31:0] wd, input logic tg, input logic [31:0] rd,
                           input int wc, input int k, input int len);
    beat_t b;
    b.addr = a; b.sel = s; b.we = we; b.wdata = wd; b.tagn = tg;
    b.rdata = rd; b.wcyc = wc; b.kind = k; b.exp_len = len;
    beat_q.push_back(b);
  endtask

  task automatic push_resp(input logic [31:0] d, input logic e, input int lat);
    resp_t r;
    r.data = d; r.err = e; r.lat = lat;
    exp_q.push_back(r);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] d, input logic we,
                     input logic [1:0] sz, input logic u);
    int n;
    @(posedge clk); #1;
    lsu_addr = a; lsu_wdata = d; lsu_we = we; lsu_size = sz; lsu_uns = u;
    req = 1'b1; req_cyc = cyc_cnt;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!gnt && n < 50);
    if (!gnt) begin
      checks++; failures++;
      $display("FAIL gnt_wait addr=0x%08h no grant within %0d cycles", a, n);
    end
    @(posedge clk); #1;
    req = 1'b0;
    chk("gnt_pulse", {31'b0, gnt}, 32'd0);
  endtask

  // Scripted slave: each STB-high stretch consumes one beat descriptor.
  always @(negedge clk) begin
    wb_ack = 1'b0; wb_err = 1'b0; wb_tagn_i = 1'b1; wb_rdata = '0;
    if (wb_stb) begin
      if (!active) begin
        if (beat_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_beat addr=0x%08h sel=%b", wb_addr, wb_sel);
          cur.kind = K_ACK; cur.wcyc = 0; cur.exp_len = 0; cur.tagn = 1'b1; cur.rdata = '0;
        end else begin
          cur = beat_q.pop_front();
          chk("wb_addr", wb_addr, cur.addr);
          chk("wb_sel", {28'b0, wb_sel}, {28'b0, cur.sel});
          chk("wb_we", {31'b0, wb_we}, {31'b0, cur.we});
          chk("wb_tagn", {31'b0, wb_tagn_o}, {31'b0, cur.tagn});
          if (cur.we) chk("wb_wdata", wb_wdata, cur.wdata);
        end
        active = 1'b1; hi_cnt = 0; waitc = cur.wcyc;
      end
      hi_cnt++;
      if (cur.kind != K_NONE) begin
        if (waitc == 0) begin
          wb_ack    = (cur.kind != K_ERR);
          wb_err    = (cur.kind == K_ERR) || (cur.kind == K_BOTH);
          wb_tagn_i = (cur.kind != K_TAG);
          wb_rdata  = cur.rdata;
        end else begin
          waitc--;
        end
      end
    end else if (active) begin
      if (cur.exp_len != 0) chk("stb_len", 32'(hi_cnt), 32'(cur.exp_len));
      if (!cur.tagn && cur.kind == K_ACK) chk("cyc_in_gap", {31'b0, wb_cyc}, 32'd1);
      active = 1'b0;
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    if (rst_n && gnt) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_gnt data=0x%08h err=%b", lsu_rdata, lerr);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        chk("lsu_data", lsu_rdata, e.data);
        chk("lsu_err", {31'b0, lerr}, {31'b0, e.err});
        chk("gnt_latency", 32'(cyc_cnt - req_cyc), 32'(e.lat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", {31'b0, wb_cyc}, 32'd0);
    chk("rst_stb", {31'b0, wb_stb}, 32'd0);
    chk("rst_gnt_err", {30'b0, gnt, lerr}, 32'd0);
    chk("rst_tagn", {31'b0, wb_tagn_o}, 32'd1);
    chk("rst_sel_data", {28'b0, wb_sel} | lsu_rdata, 32'd0);
    rst_n = 1'b1;

    // Aligned word, zero-wait slave
    push_beat(32'h1000, 4'b1111, 0, 0, 1, 32'hDEADBEEF, 0, K_ACK, 1);
    push_resp(32'hDEADBEEF, 0, 2);
    run(32'h1000, 0, 0, 2'd2, 0);
    // Byte loads, signed then unsigned
    push_beat(32'h1000, 4'b1000, 0, 0, 1, 32'h80112233, 0, K_ACK, 1);
    push_resp(32'hFFFFFF80, 0, 2);
    run(32'h1003, 0, 0, 2'd0, 0);
    push_beat(32'h1000, 4'b1000, 0, 0, 1, 32'h80112233, 0, K_ACK, 1);
    push_resp(32'h00000080, 0, 2);
    run(32'h1003, 0, 0, 2'd0, 1);
    // Halfwords, one with wait states
    push_beat(32'h1000, 4'b1100, 0, 0, 1, 32'h80112233, 2, K_ACK, 3);
    push_resp(32'hFFFF8011, 0, 4);
    run(32'h1002, 0, 0, 2'd1, 0);
    push_beat(32'h1000, 4'b0011, 0, 0, 1, 32'h1234F00D, 0, K_ACK, 1);
    push_resp(32'h0000F00D, 0, 2);
    run(32'h1000, 0, 0, 2'd1, 1);
    // Misaligned word load split in two beats
    push_beat(32'h1000, 4'b1100, 0, 0, 0, 32'hAAAA5555, 0, K_ACK, 1);
    push_beat(32'h1004, 4'b0011, 0, 0, 1, 32'h1234CCCC, 0, K_ACK, 1);
    push_resp(32'hCCCCAAAA, 0, 4);
    run(32'h1002, 0, 0, 2'd2, 0);
    // Misaligned signed halfword crossing a word
    push_beat(32'h1000, 4'b1000, 0, 0, 0, 32'hAB000000, 0, K_ACK, 1);
    push_beat(32'h1004, 4'b0001, 0, 0, 1, 32'h000000CD, 0, K_ACK, 1);
    push_resp(32'hFFFFCDAB, 0, 4);
    run(32'h1003, 0, 0, 2'd1, 0);
    // Split wrapping the top of the address space
    push_beat(32'hFFFFFFFC, 4'b1100, 0, 0, 0, 32'h12340000, 0, K_ACK, 1);
    push_beat(32'h00000000, 4'b0011, 0, 0, 1, 32'h0000ABCD, 0, K_ACK, 1);
    push_resp(32'hABCD1234, 0, 4);
    run(32'hFFFFFFFE, 0, 0, 2'd2, 0);
    // Misaligned split store, and an aligned byte store with junk upper bits
    push_beat(32'h1000, 4'b1110, 1, 32'h22334400, 0, 0, 0, K_ACK, 1);
    push_beat(32'h1004, 4'b0001, 1, 32'h00000011, 1, 0, 0, K_ACK, 1);
    push_resp(32'h0, 0, 4);
    run(32'h1001, 32'h11223344, 1, 2'd2, 0);
    push_beat(32'h2000, 4'b0100, 1, 32'h00A50000, 1, 32'hFFFFFFFF, 0, K_ACK, 1);
    push_resp(32'h0, 0, 2);
    run(32'h2002, 32'hFFFFFFA5, 1, 2'd0, 0);
    // Error paths: timeout, ERR+ACK, tag error, ERR on beat 0 of a split
    push_beat(32'h3000, 4'b1111, 0, 0, 1, 0, 0, K_NONE, 4);
    push_resp(32'h0, 1, 5);
    run(32'h3000, 0, 0, 2'd2, 0);
    push_beat(32'h3004, 4'b1111, 0, 0, 1, 32'h55555555, 0, K_BOTH, 1);
    push_resp(32'h0, 1, 2);
    run(32'h3004, 0, 0, 2'd2, 0);
    push_beat(32'h3008, 4'b1111, 0, 0, 1, 32'h66666666, 0, K_TAG, 1);
    push_resp(32'h0, 1, 2);
    run(32'h3008, 0, 0, 2'd2, 0);
    push_beat(32'h3004, 4'b1100, 0, 0, 0, 0, 0, K_ERR, 1);
    push_resp(32'h0, 1, 2);
    run(32'h3006, 0, 0, 2'd2, 0);
    // Doubleword on a 32-bit bus: error without a bus cycle
    push_resp(32'h0, 1, 1);
    run(32'h1000, 0, 0, 2'd3, 0);

    // Reset during beat 0 of a split load
    push_beat(32'h4000, 4'b1100, 0, 0, 0, 0, 0, K_NONE, 0);
    @(posedge clk); #1;
    lsu_addr = 32'h4002; lsu_we = 1'b0; lsu_size = 2'd2; lsu_uns = 1'b0; req = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_stb_before", {31'b0, wb_stb}, 32'd1);
    rst_n = 1'b0; req = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_cyc", {31'b0, wb_cyc}, 32'd0);
    chk("rst_mid_stb", {31'b0, wb_stb}, 32'd0);
    chk("rst_mid_gnt", {31'b0, gnt}, 32'd0);
    chk("rst_mid_tagn", {31'b0, wb_tagn_o}, 32'd1);
    rst_n = 1'b1;
    push_beat(32'h1000, 4'b1111, 0, 0, 1, 32'h0BADF00D, 0, K_ACK, 1);
    push_resp(32'h0BADF00D, 0, 2);
    run(32'h1000, 0, 0, 2'd2, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("resp_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("beat_queue_drained", 32'(beat_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
